// File: rtl/svga_timing_pkg.sv
// Shared display-timing constants and helpers.
// Pixel generators reuse these to stay in step with svga_timing.
package svga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 800;
   localparam int unsigned DEF_H_FP     = 40;
   localparam int unsigned DEF_H_SYNC   = 128;
   localparam int unsigned DEF_H_BP     = 88;
   localparam int unsigned DEF_V_ACTIVE = 600;
   localparam int unsigned DEF_V_FP     = 1;
   localparam int unsigned DEF_V_SYNC   = 4;
   localparam int unsigned DEF_V_BP     = 23;

   localparam int unsigned HCOUNT_W = 11;
   localparam int unsigned VCOUNT_W = 10;

   function automatic int unsigned timing_total(input int unsigned active, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
      return active + fp;
   endfunction

   function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync);
      return active + fp + sync;
   endfunction

   localparam int unsigned DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int unsigned DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/svga_timing.sv
// Free-running raster counters with registered sync/blank/frame_start, all aligned to hcount/vcount.
// Outputs describe the position they are presented with; no backpressure, runs every pixel clock.
module svga_timing
   import svga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          SYNC_POL = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   output logic [HCOUNT_W-1:0] hcount,
   output logic [VCOUNT_W-1:0] vcount,
   output logic                hsync,
   output logic                vsync,
   output logic                blank,
   output logic                frame_start
);

   localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
   localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOTAL - 1);
   localparam logic [HCOUNT_W-1:0] H_VIS    = HCOUNT_W'(H_ACTIVE);
   localparam logic [VCOUNT_W-1:0] V_VIS    = VCOUNT_W'(V_ACTIVE);
   localparam logic [HCOUNT_W-1:0] HS_START = HCOUNT_W'(sync_start(H_ACTIVE, H_FP));
   localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
   localparam logic [VCOUNT_W-1:0] VS_START = VCOUNT_W'(sync_start(V_ACTIVE, V_FP));
   localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

   logic                h_wrap;
   logic                v_wrap;
   logic [HCOUNT_W-1:0] h_nxt;
   logic [VCOUNT_W-1:0] v_nxt;

   always_comb begin
      h_wrap = (hcount == H_LAST);
      v_wrap = (vcount == V_LAST);
      h_nxt  = h_wrap ? '0 : hcount + HCOUNT_W'(1);
      v_nxt  = vcount;
      if (h_wrap) begin
         v_nxt = v_wrap ? '0 : vcount + VCOUNT_W'(1);
      end
   end

   // Flags are decoded from the next position so they land in the same cycle as the counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount      <= '0;
         vcount      <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         blank       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hcount      <= h_nxt;
         vcount      <= v_nxt;
         hsync       <= (h_nxt >= HS_START && h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
         vsync       <= (v_nxt >= VS_START && v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
         blank       <= (h_nxt >= H_VIS) || (v_nxt >= V_VIS);
         frame_start <= h_wrap && v_wrap;
      end
   end

endmodule

// File: doc/svga_timing.md
SVGA_TIMING -- requirements
Module: svga_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 128, hsync pulse width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 88, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 1, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 4, vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 23, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_POL, default 1, sync active level (1 = active-high).
REQ-010 The block SHALL have port clk, input, 1 bit: pixel clock (40 MHz for defaults); the block has one clock.
REQ-011 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-012 The block SHALL have port hcount, output, 11 bits: pixel column, 0..H_TOTAL-1.
REQ-013 The block SHALL have port vcount, output, 10 bits: line number, 0..V_TOTAL-1.
REQ-014 The block SHALL have port hsync, output, 1 bit: horizontal sync at SYNC_POL level.
REQ-015 The block SHALL have port vsync, output, 1 bit: vertical sync at SYNC_POL level.
REQ-016 The block SHALL have port blank, output, 1 bit: high outside the visible region.
REQ-017 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse on the first pixel of each frame.

Function
REQ-018 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (1056 default), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (628 default).
REQ-019 hcount SHALL increment by 1 every clk; at H_TOTAL-1 it SHALL wrap to 0 on the next clk.
REQ-020 vcount SHALL increment only on the clk where hcount wraps; at V_TOTAL-1 it SHALL wrap to 0 together with hcount.
REQ-021 All outputs SHALL be registered and mutually aligned: each flag describes the hcount/vcount value presented in the same cycle.
REQ-022 hsync SHALL be at SYNC_POL level iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967 default), and at the opposite level otherwise.
REQ-023 vsync SHALL be at SYNC_POL level iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604 default), for every hcount on those lines.
REQ-024 blank SHALL be 1 iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
REQ-025 frame_start SHALL be 1 for exactly one clk, the cycle in which hcount=0 and vcount=0 following a wrap from (H_TOTAL-1, V_TOTAL-1); it SHALL NOT fire in the cycle after reset release.
REQ-026 Counter comparisons SHALL be unsigned; the counters SHALL never hold values >= H_TOTAL or >= V_TOTAL.

Reset
REQ-027 While reset=1: hcount=0, vcount=0, blank=0, frame_start=0, and hsync/vsync at the inactive level (~SYNC_POL), asynchronously.
REQ-028 On the first clk after reset deassertion, hcount SHALL become 1 (counting resumes from position 0,0); reset asserted mid-frame SHALL abandon the frame immediately.

Structure
REQ-029 The timing constants (defaults, H_TOTAL, V_TOTAL, sync start/end) SHALL live in a shared display-timing package for reuse by the pixel generators.
REQ-030 The block SHALL be a single module with no sub-modules; the pixel-generation stage consumes hcount, vcount, vsync and blank directly.

Verification
REQ-031 The bench SHALL release reset and run 1056 clks -> hcount runs 0..1055 then 0, vcount steps 0->1 exactly at the wrap.
REQ-032 The bench SHALL measure the hsync pulse -> active for exactly 128 clks, starting when hcount=840; blank rises at hcount=800.
REQ-033 The bench SHALL run one full frame (663,168 clks) -> vsync is active on lines 601..604 only, and frame_start pulses exactly once, at (0,0).
REQ-034 The bench SHALL assert reset at (hcount=500, vcount=300) for 3 clks, between clk edges -> outputs reset immediately and counting restarts at 0,0 with no frame_start.
REQ-035 The bench SHALL instantiate with SYNC_POL=0 -> hsync and vsync are inverted, while counters and blank are unchanged.
